rv32_mod_fetch: RTL and testbench

- Instruction fetch and PC unit for the rv32imc single-stage core; it is the consumer of the branch unit's branch_taken decision.
- Holds the architectural PC and issues word-aligned instruction-memory reads over a req/ack handshake.
- Realigns 16/32-bit (RVC) instructions, including 32-bit instructions that span a word boundary, and presents one instruction at a time to decode with valid/ready.
- On branch_taken it flushes its buffers and redirects to branch_target.

---
 rtl/rv32_mod_fetch_if.sv | 25 ++
 rtl/rv32_mod_fetch.sv | 146 ++++++++++++++
 tb/tb_rv32_mod_fetch.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/rv32_mod_fetch_if.sv
// Instruction-memory request/ack bus, decode valid/ready handshake and branch
// redirect signals of the rv32imc fetch unit.
interface rv32_mod_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_is_rvc;
  logic        branch_taken;
  logic [31:0] branch_target;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc, instr_is_rvc,
    input  imem_ack, imem_rdata, instr_ready, branch_taken, branch_target
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc, instr_is_rvc,
    output imem_ack, imem_rdata, instr_ready, branch_taken, branch_target
  );
endinterface

// File: rtl/rv32_mod_fetch.sv
// Fetch/PC unit: one-word buffer plus a carried low half for 32-bit
// instructions that straddle a word boundary; all outputs are registered.
module rv32_mod_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic              clk,
  input logic              rst,
  rv32_mod_fetch_if.master bus
);
  localparam logic [31:0] PC_RST   = RESET_PC & ~32'h1;
  localparam logic [31:0] ADDR_RST = RESET_PC & ~32'h3;

  logic [31:0] r_pc;
  logic [31:0] r_buf_word;
  logic        r_buf_valid;
  logic [15:0] r_carry_half;
  logic        r_carry_valid;
  logic        r_pend;
  logic        r_drop;
  logic [31:0] r_addr;
  logic        r_instr_valid;
  logic [31:0] r_instr;
  logic [31:0] r_instr_pc;
  logic        r_instr_is_rvc;

  logic        w_ack;
  logic        w_outstanding;
  logic        w_consume;
  logic        w_split;
  logic [31:0] w_fetch_pc;
  logic [31:0] w_pc_n;
  logic [31:0] w_buf_word_n;
  logic        w_buf_valid_n;
  logic [15:0] w_carry_half_n;
  logic        w_carry_valid_n;
  logic        w_pend_n;
  logic        w_drop_n;
  logic [31:0] w_fetch_pc_n;
  logic [31:0] w_addr_n;
  logic [15:0] w_half_n;
  logic        w_valid_n;
  logic [31:0] w_instr_n;
  logic        w_rvc_n;

  assign bus.imem_req     = r_pend;
  assign bus.imem_addr    = r_addr;
  assign bus.instr_valid  = r_instr_valid;
  assign bus.instr        = r_instr;
  assign bus.instr_pc     = r_instr_pc;
  assign bus.instr_is_rvc = r_instr_is_rvc;

  assign w_ack         = bus.imem_ack && r_pend;
  assign w_outstanding = r_pend && !bus.imem_ack;
  assign w_consume     = r_instr_valid && bus.instr_ready && !bus.branch_taken;
  assign w_fetch_pc    = r_carry_valid ? (r_pc + 32'd2) : r_pc;
  assign w_split       = r_buf_valid && r_pc[1] && !r_carry_valid &&
                         (r_buf_word[17:16] == 2'b11);

  always_comb begin
    w_pc_n          = r_pc;
    w_buf_word_n    = r_buf_word;
    w_buf_valid_n   = r_buf_valid;
    w_carry_half_n  = r_carry_half;
    w_carry_valid_n = r_carry_valid;

    if (bus.branch_taken) begin
      w_pc_n          = bus.branch_target & ~32'h1;
      w_buf_valid_n   = 1'b0;
      w_carry_valid_n = 1'b0;
    end else begin
      if (w_ack && !r_drop) begin
        w_buf_word_n  = bus.imem_rdata;
        w_buf_valid_n = 1'b1;
      end
      // The buffer holds word fetch_pc[31:2]; after a spanning instruction
      // that is already the word the new pc points into, so it is kept.
      if (w_consume) begin
        w_pc_n          = r_pc + (r_instr_is_rvc ? 32'd2 : 32'd4);
        w_carry_valid_n = 1'b0;
        if (w_pc_n[31:2] != w_fetch_pc[31:2]) begin
          w_buf_valid_n = 1'b0;
        end
      end else if (w_split) begin
        w_carry_half_n  = r_buf_word[31:16];
        w_carry_valid_n = 1'b1;
        w_buf_valid_n   = 1'b0;
      end
    end

    // A single drop flag suffices because at most one request is in flight.
    w_drop_n     = w_outstanding && (bus.branch_taken || r_drop);
    w_pend_n     = w_outstanding || !w_buf_valid_n;
    w_fetch_pc_n = w_carry_valid_n ? (w_pc_n + 32'd2) : w_pc_n;
    w_addr_n     = w_outstanding ? r_addr : {w_fetch_pc_n[31:2], 2'b00};

    w_half_n  = w_pc_n[1] ? w_buf_word_n[31:16] : w_buf_word_n[15:0];
    w_valid_n = 1'b0;
    w_instr_n = r_instr;
    w_rvc_n   = r_instr_is_rvc;
    if (w_buf_valid_n) begin
      if (w_carry_valid_n) begin
        w_valid_n = 1'b1;
        w_instr_n = {w_buf_word_n[15:0], w_carry_half_n};
        w_rvc_n   = 1'b0;
      end else if (w_half_n[1:0] != 2'b11) begin
        w_valid_n = 1'b1;
        w_instr_n = {16'h0000, w_half_n};
        w_rvc_n   = 1'b1;
      end else if (!w_pc_n[1]) begin
        w_valid_n = 1'b1;
        w_instr_n = w_buf_word_n;
        w_rvc_n   = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc           <= PC_RST;
      r_buf_word     <= '0;
      r_buf_valid    <= 1'b0;
      r_carry_half   <= '0;
      r_carry_valid  <= 1'b0;
      r_pend         <= 1'b0;
      r_drop         <= 1'b0;
      r_addr         <= ADDR_RST;
      r_instr_valid  <= 1'b0;
      r_instr        <= '0;
      r_instr_pc     <= PC_RST;
      r_instr_is_rvc <= 1'b0;
    end else begin
      r_pc           <= w_pc_n;
      r_buf_word     <= w_buf_word_n;
      r_buf_valid    <= w_buf_valid_n;
      r_carry_half   <= w_carry_half_n;
      r_carry_valid  <= w_carry_valid_n;
      r_pend         <= w_pend_n;
      r_drop         <= w_drop_n;
      r_addr         <= w_addr_n;
      r_instr_valid  <= w_valid_n;
      r_instr        <= w_instr_n;
      r_instr_pc     <= w_pc_n;
      r_instr_is_rvc <= w_rvc_n;
    end
  end
endmodule

// File: tb/tb_rv32_mod_fetch.sv
// Directed cycle-by-cycle vectors for rv32_mod_fetch plus hand-written
// backpressure and reset-during-request sequences.
module tb_rv32_mod_fetch;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rv32_mod_fetch_if bus();

  rv32_mod_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        rst;
    logic        ack;
    logic [31:0] rdata;
    logic        rdy;
    logic        br;
    logic [31:0] tgt;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_val;
    logic [31:0] e_instr;
    logic [31:0] e_pc;
    logic        e_rvc;
  } vec_t;

  vec_t        tv[$];
  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic add(input logic r, input logic a, input logic [31:0] d,
                     input logic rd, input logic b, input logic [31:0] t,
                     input logic er, input logic [31:0] ea,
                     input logic ev, input logic [31:0] ei, input logic [31:0] ep,
                     input logic erv);
    vec_t v;
    v.rst = r; v.ack = a; v.rdata = d; v.rdy = rd; v.br = b; v.tgt = t;
    v.e_req = er; v.e_addr = ea; v.e_val = ev; v.e_instr = ei; v.e_pc = ep; v.e_rvc = erv;
    tv.push_back(v);
  endtask

  task automatic drive(input logic r, input logic a, input logic [31:0] d,
                       input logic rd, input logic b, input logic [31:0] t);
    @(negedge clk);
    rst               = r;
    bus.imem_ack      = a;
    bus.imem_rdata    = d;
    bus.instr_ready   = rd;
    bus.branch_taken  = b;
    bus.branch_target = t;
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // addr is checked only while a request is expected, instr fields only while
  // valid is expected; 'full' forces every field (reset values).
  task automatic expect_out(input string tag, input logic full, input logic er,
                            input logic [31:0] ea, input logic ev,
                            input logic [31:0] ei, input logic [31:0] ep,
                            input logic erv);
    n_vec++;
    chk({tag, ".imem_req"}, {31'b0, bus.imem_req}, {31'b0, er});
    chk({tag, ".instr_valid"}, {31'b0, bus.instr_valid}, {31'b0, ev});
    if (full || er) chk({tag, ".imem_addr"}, bus.imem_addr, ea);
    if (full || ev) begin
      chk({tag, ".instr"}, bus.instr, ei);
      chk({tag, ".instr_pc"}, bus.instr_pc, ep);
      chk({tag, ".instr_is_rvc"}, {31'b0, bus.instr_is_rvc}, {31'b0, erv});
    end
  endtask

  initial begin
    bus.imem_ack      = 1'b0;
    bus.imem_rdata    = '0;
    bus.instr_ready   = 1'b0;
    bus.branch_taken  = 1'b0;
    bus.branch_target = '0;

    // Sequential 32-bit words, ack latency 0 then 2
    add(1,0,32'h0,1,0,0, 0,32'h0, 0,32'h0,32'h0,0);
    add(0,0,32'h0,1,0,0, 0,0, 0,0,0,0);
    add(0,1,32'h13,1,0,0, 1,32'h0, 0,0,0,0);
    add(0,0,32'h0,1,0,0, 0,0, 1,32'h13,32'h0,0);
    add(0,0,32'h0,1,0,0, 1,32'h4, 0,0,0,0);
    add(0,0,32'h0,1,0,0, 1,32'h4, 0,0,0,0);
    add(0,1,32'h13,1,0,0, 1,32'h4, 0,0,0,0);
    add(0,0,32'h0,1,0,0, 0,0, 1,32'h13,32'h4,0);
    add(0,1,32'h13,1,0,0, 1,32'h8, 0,0,0,0);
    add(0,0,32'h0,1,0,0, 0,0, 1,32'h13,32'h8,0);
    add(1,0,32'h0,1,0,0, 0,32'h0, 0,32'h0,32'h0,0);
    // RVC pair in one word, single request
    add(0,0,32'h0,1,0,0, 0,0, 0,0,0,0);
    add(0,1,32'h0001_0001,1,0,0, 1,32'h0, 0,0,0,0);
    add(0,0,32'h0,1,0,0, 0,0, 1,32'h1,32'h0,1);
    add(0,0,32'h0,1,0,0, 0,0, 1,32'h1,32'h2,1);
    add(0,0,32'h0,1,0,0, 1,32'h4, 0,0,0,0);
    add(1,0,32'h0,1,0,0, 0,32'h0, 0,32'h0,32'h0,0);
    // RVC then a 32-bit instruction spanning words 0 and 4
    add(0,0,32'h0,1,0,0, 0,0, 0,0,0,0);
    add(0,1,32'h0093_0001,1,0,0, 1,32'h0, 0,0,0,0);
    add(0,0,32'h0,1,0,0, 0,0, 1,32'h1,32'h0,1);
    add(0,0,32'h0,1,0,0, 0,0, 0,0,0,0);
    add(0,1,32'h0001_0050,1,0,0, 1,32'h4, 0,0,0,0);
    add(0,0,32'h0,1,0,0, 0,0, 1,32'h0050_0093,32'h2,0);
    add(0,0,32'h0,1,0,0, 0,0, 1,32'h1,32'h6,1);
    add(0,0,32'h0,1,0,0, 1,32'h8, 0,0,0,0);
    add(1,0,32'h0,1,0,0, 0,32'h0, 0,32'h0,32'h0,0);
    // Redirects: in-flight drop, handshake+branch, ack+branch, wrap, span at top
    add(0,0,32'h0,1,0,0, 0,0, 0,0,0,0);
    add(0,1,32'h13,1,0,0, 1,32'h0, 0,0,0,0);
    add(0,0,32'h0,1,0,0, 0,0, 1,32'h13,32'h0,0);
    add(0,1,32'h13,1,0,0, 1,32'h4, 0,0,0,0);
    add(0,0,32'h0,1,0,0, 0,0, 1,32'h13,32'h4,0);
    add(0,0,32'h0,1,1,32'h101, 1,32'h8, 0,0,0,0);
    add(0,0,32'h0,1,0,0, 1,32'h8, 0,0,0,0);
    add(0,1,32'h33,1,0,0, 1,32'h8, 0,0,0,0);
    add(0,1,32'h13,1,0,0, 1,32'h100, 0,0,0,0);
    add(0,0,32'h0,1,1,32'h200, 0,0, 1,32'h13,32'h100,0);
    add(0,1,32'h13,1,1,32'hFFFF_FFFC, 1,32'h200, 0,0,0,0);
    add(0,1,32'h13,1,0,0, 1,32'hFFFF_FFFC, 0,0,0,0);
    add(0,0,32'h0,1,0,0, 0,0, 1,32'h13,32'hFFFF_FFFC,0);
    add(0,0,32'h0,1,1,32'hFFFF_FFFE, 1,32'h0, 0,0,0,0);
    add(0,1,32'h5,1,0,0, 1,32'h0, 0,0,0,0);
    add(0,1,32'h0093_0001,1,0,0, 1,32'hFFFF_FFFC, 0,0,0,0);
    add(0,0,32'h0,1,0,0, 0,0, 0,0,0,0);
    add(0,1,32'h0001_0050,1,0,0, 1,32'h0, 0,0,0,0);
    add(0,0,32'h0,1,0,0, 0,0, 1,32'h0050_0093,32'hFFFF_FFFE,0);
    add(0,0,32'h0,1,0,0, 0,0, 1,32'h1,32'h2,1);

    foreach (tv[i]) begin
      drive(tv[i].rst, tv[i].ack, tv[i].rdata, tv[i].rdy, tv[i].br, tv[i].tgt);
      expect_out($sformatf("v%0d", i), tv[i].rst, tv[i].e_req, tv[i].e_addr,
                 tv[i].e_val, tv[i].e_instr, tv[i].e_pc, tv[i].e_rvc);
    end

    // Backpressure: instruction held for 5 cycles, no extra request
    drive(1,0,0,0,0,0); expect_out("bp.rst", 1, 0,32'h0, 0,32'h0,32'h0,0);
    drive(0,0,0,0,0,0); expect_out("bp.idle", 0, 0,0, 0,0,0,0);
    drive(0,1,32'h13,0,0,0); expect_out("bp.ack", 0, 1,32'h0, 0,0,0,0);
    for (int k = 0; k < 5; k++) begin
      drive(0,0,0,0,0,0);
      expect_out($sformatf("bp.hold%0d", k), 0, 0,0, 1,32'h13,32'h0,0);
    end
    drive(0,0,0,1,0,0); expect_out("bp.take", 0, 0,0, 1,32'h13,32'h0,0);
    drive(0,0,0,0,0,0); expect_out("bp.next", 0, 1,32'h4, 0,0,0,0);

    // Redirect to 0x40, then reset while that request is outstanding
    drive(0,0,0,0,1,32'h40); expect_out("rr.br", 0, 1,32'h4, 0,0,0,0);
    drive(0,1,32'hDEAD_BEEF,0,0,0); expect_out("rr.drop", 0, 1,32'h4, 0,0,0,0);
    drive(0,0,0,0,0,0); expect_out("rr.req40", 0, 1,32'h40, 0,0,0,0);
    drive(1,0,0,0,0,0); expect_out("rr.rst", 1, 0,32'h0, 0,32'h0,32'h0,0);
    drive(0,0,0,0,0,0); expect_out("rr.rel", 0, 0,0, 0,0,0,0);
    drive(0,0,0,0,0,0); expect_out("rr.req0", 0, 1,32'h0, 0,0,0,0);
    drive(0,1,32'h13,1,0,0); expect_out("rr.ack0", 0, 1,32'h0, 0,0,0,0);
    drive(0,0,0,1,0,0); expect_out("rr.inst", 0, 0,0, 1,32'h13,32'h0,0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
